// File: rtl/ser_pkg.sv
// Shared definitions for the serial link: symbol/frame geometry, comma code
// and the receive deframer state encoding.
package ser_pkg;

  localparam logic [7:0] COMMA   = 8'h3C;
  localparam logic       KCODE   = 1'b1;
  localparam int         SYM_W   = 9;
  localparam int         FRAME_W = 27;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_D0,
    ST_D1,
    ST_D2
  } deframe_state_e;

  function automatic logic is_comma(input logic [SYM_W-1:0] sym);
    return sym == {KCODE, COMMA};
  endfunction

endpackage

// File: rtl/deserializer_out.sv
// Receive deframer: finds the comma, gathers the next three symbols into one
// 27-bit word and tracks frame lock with good/bad hysteresis counters.
module deserializer_out
  import ser_pkg::*;
#(
  parameter int LOCK_CNT   = 4,
  parameter int UNLOCK_CNT = 2
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [SYM_W-1:0]   sym_i,
  input  logic               sym_valid_i,
  output logic [FRAME_W-1:0] data_o,
  output logic               valid_o,
  output logic               locked_o,
  output logic               err_o
);

  localparam int            GW       = $clog2(LOCK_CNT + 1);
  localparam int            BW       = $clog2(UNLOCK_CNT + 1);
  localparam logic [GW-1:0] GOOD_MAX = GW'(LOCK_CNT);
  localparam logic [BW-1:0] BAD_MAX  = BW'(UNLOCK_CNT);

  deframe_state_e     r_state;
  deframe_state_e     w_state_next;
  logic [SYM_W-1:0]   r_slot0;
  logic [SYM_W-1:0]   r_slot1;
  logic [GW-1:0]      r_good_cnt;
  logic [BW-1:0]      r_bad_cnt;
  logic [FRAME_W-1:0] r_data;
  logic               r_valid;
  logic               r_locked;
  logic               r_err;

  logic               w_comma;
  logic               w_cap0;
  logic               w_cap1;
  logic               w_good;
  logic               w_bad;
  logic [GW-1:0]      w_good_inc;
  logic [BW-1:0]      w_bad_inc;

  assign w_comma    = is_comma(sym_i);
  assign w_good_inc = (r_good_cnt == GOOD_MAX) ? GOOD_MAX : r_good_cnt + GW'(1);
  assign w_bad_inc  = (r_bad_cnt == BAD_MAX) ? BAD_MAX : r_bad_cnt + BW'(1);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (sym_valid_i) begin
      if (w_comma) begin
        w_state_next = ST_D0;
      end else begin
        case (r_state)
          ST_IDLE: w_state_next = ST_IDLE;
          ST_D0:   w_state_next = ST_D1;
          ST_D1:   w_state_next = ST_D2;
          default: w_state_next = ST_IDLE;
        endcase
      end
    end
  end

  // Repeated commas in ST_D0 are idle fill, so only D1/D2 commas abort a frame.
  always_comb begin
    w_cap0 = 1'b0;
    w_cap1 = 1'b0;
    w_good = 1'b0;
    w_bad  = 1'b0;
    if (sym_valid_i) begin
      case (r_state)
        ST_IDLE: w_bad = !w_comma && r_locked;
        ST_D0:   w_cap0 = !w_comma;
        ST_D1: begin
          w_cap1 = !w_comma;
          w_bad  = w_comma;
        end
        default: begin
          w_good = !w_comma;
          w_bad  = w_comma;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_slot0 <= '0;
      r_slot1 <= '0;
    end else begin
      if (w_cap0) r_slot0 <= sym_i;
      if (w_cap1) r_slot1 <= sym_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_good_cnt <= '0;
      r_bad_cnt  <= '0;
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_locked   <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      if (w_good) begin
        r_good_cnt <= w_good_inc;
        r_bad_cnt  <= '0;
        if (r_locked || (w_good_inc == GOOD_MAX)) begin
          r_locked <= 1'b1;
          r_valid  <= 1'b1;
          r_data   <= {sym_i, r_slot1, r_slot0};
        end
      end else if (w_bad) begin
        if (!r_locked) begin
          r_good_cnt <= '0;
        end else begin
          r_err <= 1'b1;
          if (w_bad_inc == BAD_MAX) begin
            r_locked   <= 1'b0;
            r_good_cnt <= '0;
            r_bad_cnt  <= '0;
          end else begin
            r_bad_cnt <= w_bad_inc;
          end
        end
      end
    end
  end

  assign data_o   = r_data;
  assign valid_o  = r_valid;
  assign locked_o = r_locked;
  assign err_o    = r_err;

endmodule

// File: tb/tb_deserializer_out.sv
// Directed bench for deserializer_out: a queue-based frame model predicts the
// outputs every cycle, and literal expectations pin the key frames.
module tb_deserializer_out;

  localparam int LOCK_CNT   = 4;
  localparam int UNLOCK_CNT = 2;
  localparam logic [8:0] K_COMMA = 9'h13C;

  logic        clk;
  logic        rst_n;
  logic [8:0]  sym;
  logic        sym_valid;
  logic [26:0] data;
  logic        valid;
  logic        locked;
  logic        err;

  deserializer_out #(
    .LOCK_CNT  (LOCK_CNT),
    .UNLOCK_CNT(UNLOCK_CNT)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .sym_i      (sym),
    .sym_valid_i(sym_valid),
    .data_o     (data),
    .valid_o    (valid),
    .locked_o   (locked),
    .err_o      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n_valid = 0;
  int n_err = 0;

  // Model: frame position is the number of data symbols queued since a comma.
  logic [8:0]  m_q[$];
  bit          m_inframe;
  bit          m_locked;
  int          m_good;
  int          m_bad;
  logic [26:0] m_data;

  logic        pend_valid, pend_err, pend_locked;
  logic [26:0] pend_data;
  logic        exp_valid, exp_err, exp_locked;
  logic [26:0] exp_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_inframe = 0;
    m_locked = 0;
    m_good = 0;
    m_bad = 0;
    m_data = '0;
    pend_valid = 0; pend_err = 0; pend_locked = 0; pend_data = '0;
    exp_valid = 0; exp_err = 0; exp_locked = 0; exp_data = '0;
  endtask

  task automatic model_step(input logic v, input logic [8:0] s);
    bit good, bad;
    logic [26:0] word;
    good = 0; bad = 0; word = '0;
    pend_valid = 0;
    pend_err = 0;
    if (v) begin
      if (s == K_COMMA) begin
        if (m_inframe && m_q.size() > 0) bad = 1;
        m_inframe = 1;
        m_q.delete();
      end else if (!m_inframe) begin
        if (m_locked) bad = 1;
      end else begin
        m_q.push_back(s);
        if (m_q.size() == 3) begin
          good = 1;
          word = {m_q[2], m_q[1], m_q[0]};
          m_q.delete();
          m_inframe = 0;
        end
      end
      if (good) begin
        m_good = (m_good + 1 > LOCK_CNT) ? LOCK_CNT : m_good + 1;
        m_bad = 0;
        if (m_good == LOCK_CNT) m_locked = 1;
        if (m_locked) begin
          pend_valid = 1;
          m_data = word;
        end
      end else if (bad) begin
        if (!m_locked) begin
          m_good = 0;
        end else begin
          pend_err = 1;
          m_bad++;
          if (m_bad >= UNLOCK_CNT) begin
            m_locked = 0;
            m_good = 0;
            m_bad = 0;
          end
        end
      end
    end
    pend_data = m_data;
    pend_locked = m_locked;
  endtask

  always @(negedge clk) begin
    chk("valid_o", 32'(valid), 32'(exp_valid));
    chk("err_o", 32'(err), 32'(exp_err));
    chk("locked_o", 32'(locked), 32'(exp_locked));
    chk("data_o", 32'(data), 32'(exp_data));
    if (valid === 1'b1) n_valid++;
    if (err === 1'b1) n_err++;
  end

  task automatic tick(input logic v, input logic [8:0] s);
    @(posedge clk);
    #1;
    exp_valid = pend_valid;
    exp_err = pend_err;
    exp_locked = pend_locked;
    exp_data = pend_data;
    sym = s;
    sym_valid = v;
    model_step(v, s);
  endtask

  task automatic send(input logic [8:0] s, input int gap);
    tick(1'b1, s);
    repeat (gap) tick(1'b0, 9'h000);
  endtask

  task automatic frame(input logic [8:0] d0, input logic [8:0] d1, input logic [8:0] d2,
                       input int gap);
    send(K_COMMA, gap);
    send(d0, gap);
    send(d1, gap);
    send(d2, gap);
  endtask

  task automatic settle();
    tick(1'b0, 9'h000);
    tick(1'b0, 9'h000);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  int v0, e0;

  initial begin
    rst_n = 1'b0;
    sym = '0;
    sym_valid = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_data", 32'(data), 32'h0);
    chk("reset_locked", 32'(locked), 32'h0);
    rst_n = 1'b1;

    // Lock acquisition: only the 4th frame is delivered.
    v0 = n_valid;
    repeat (3) frame(9'h011, 9'h022, 9'h033, 0);
    settle();
    chk("lock_no_valid", 32'(n_valid - v0), 32'd0);
    chk("lock_not_yet", 32'(locked), 32'h0);
    frame(9'h011, 9'h022, 9'h033, 0);
    settle();
    chk("lock_valid", 32'(n_valid - v0), 32'd1);
    chk("lock_locked", 32'(locked), 32'h1);
    chk("lock_data", 32'(data), 32'h0CC4411);

    // Idle fill then a frame carrying a K data symbol in slot 1.
    v0 = n_valid; e0 = n_err;
    repeat (10) send(K_COMMA, 0);
    send(9'h011, 0); send(9'h1BC, 0); send(9'h033, 0);
    settle();
    chk("idle_err", 32'(n_err - e0), 32'd0);
    chk("idle_valid", 32'(n_valid - v0), 32'd1);
    chk("idle_data", 32'(data), 32'h0CF7811);
    chk("idle_slot1", 32'(data[17:9]), 32'h1BC);

    // Abort mid-frame; the comma restarts a frame.
    v0 = n_valid; e0 = n_err;
    send(K_COMMA, 0); send(9'h0AA, 0);
    frame(9'h001, 9'h002, 9'h003, 0);
    settle();
    chk("abort_err", 32'(n_err - e0), 32'd1);
    chk("abort_valid", 32'(n_valid - v0), 32'd1);
    chk("abort_data", 32'(data), 32'h00C0401);
    chk("abort_locked", 32'(locked), 32'h1);

    // Loss of lock from two stray symbols in idle.
    v0 = n_valid; e0 = n_err;
    send(9'h055, 0); send(9'h055, 0);
    settle();
    chk("loss_err", 32'(n_err - e0), 32'd2);
    chk("loss_locked", 32'(locked), 32'h0);
    repeat (3) frame(9'h011, 9'h022, 9'h033, 0);
    settle();
    chk("loss_no_valid", 32'(n_valid - v0), 32'd0);
    chk("loss_data_hold", 32'(data), 32'h00C0401);
    frame(9'h011, 9'h022, 9'h033, 0);
    settle();
    chk("relock_valid", 32'(n_valid - v0), 32'd1);
    chk("relock_locked", 32'(locked), 32'h1);

    // Strobe every 10 cycles.
    v0 = n_valid;
    frame(9'h044, 9'h055, 9'h066, 9);
    settle();
    chk("gap_valid", 32'(n_valid - v0), 32'd1);
    chk("gap_data", 32'(data), 32'h198AA44);

    // Reset between the 2nd and 3rd data symbols.
    send(K_COMMA, 9); send(9'h077, 9); send(9'h088, 9);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    sym_valid = 1'b0;
    #1;
    chk("rst_async_locked", 32'(locked), 32'h0);
    chk("rst_async_data", 32'(data), 32'h0);
    chk("rst_async_valid", 32'(valid), 32'h0);
    chk("rst_async_err", 32'(err), 32'h0);
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    v0 = n_valid;
    repeat (3) frame(9'h011, 9'h022, 9'h033, 9);
    settle();
    chk("rst_no_valid", 32'(n_valid - v0), 32'd0);
    chk("rst_not_locked", 32'(locked), 32'h0);
    frame(9'h011, 9'h022, 9'h033, 9);
    settle();
    chk("rst_relock_valid", 32'(n_valid - v0), 32'd1);
    chk("rst_relock_data", 32'(data), 32'h0CC4411);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/deserializer_out.md
# deserializer_out

Receive-side frame deframer directly downstream of the serial receiver.
- Consumes decoded 9-bit symbols ({k, byte}) at one strobe per symbol.
- Locates the K-code comma (k=1, 0x3C) and reassembles the following three symbols into the 27-bit word that the transmit serializer sent.
- Maintains a frame-lock indication with hysteresis; only locked frames are delivered downstream.

## Interface
Parameters:
- LOCK_CNT, default 4: consecutive good frames required to assert lock.
- UNLOCK_CNT, default 2: consecutive bad events while locked required to drop lock.

Ports:
- clk_i, input, 1: the block's single clock.
- rst_ni, input, 1: reset, asynchronous and active-low.
- sym_i, input, 9: decoded symbol; bit 8 = k flag, bits 7:0 = byte.
- sym_valid_i, input, 1: single-cycle strobe; sym_i is valid this cycle.
- data_o, output, 27: reassembled frame; [8:0] = 1st, [17:9] = 2nd, [26:18] = 3rd symbol after the comma.
- valid_o, output, 1: one-cycle pulse; data_o carries a new frame.
- locked_o, output, 1: frame lock achieved.
- err_o, output, 1: one-cycle pulse on a framing error while locked.

## Operation
- Comma = sym_i == {1'b1, 8'h3C}. Other K symbols in data slots are legal and are passed through unchanged.
- FSM states and transitions (all advance only on sym_valid_i=1; with sym_valid_i=0 every register holds):
  - ST_IDLE: on comma, go to ST_D0. On a non-comma, stay in ST_IDLE; this counts as a bad event when locked, otherwise it is ignored.
  - ST_D0: on a non-comma, capture into slot 0 and go to ST_D1.
  - ST_D1: on a non-comma, capture into slot 1 and go to ST_D2.
  - ST_D2: on a non-comma, capture into slot 2 and go to ST_IDLE; this completes a good frame.
  - Comma in ST_D0, ST_D1 or ST_D2: the frame is aborted and counts as a bad event. The comma starts a new frame, so next state is ST_D0 and partial slots are discarded.
  - Repeated commas in ST_IDLE are idle fill; ST_IDLE→ST_D0 on the first, then ST_D0 re-entered on each further comma? No: a comma in ST_D0 is an abort only if slots were captured. Rule: a comma in ST_D0 keeps ST_D0 and is not a bad event. Commas in ST_D1 or ST_D2 are bad events.
- Lock counters:
  - good_cnt, width $clog2(LOCK_CNT+1), saturates at LOCK_CNT.
  - bad_cnt, width $clog2(UNLOCK_CNT+1), saturates at UNLOCK_CNT.
- Good frame: good_cnt++ and bad_cnt cleared.
  - If good_cnt reaches LOCK_CNT, locked_o=1.
  - The frame is emitted (valid_o) if locked_o was already 1 or becomes 1 on this frame.
- Bad event while unlocked: good_cnt cleared, no err_o.
- Bad event while locked: err_o pulse and bad_cnt++.
  - If bad_cnt reaches UNLOCK_CNT, locked_o=0 and both counters are cleared.
- data_o updates only with valid_o and holds its value between frames.

## Timing
- Reset (rst_ni=0, asynchronous): state ST_IDLE, counters 0, data_o=0, valid_o=0, locked_o=0, err_o=0.
  - Reset mid-frame discards the partial frame.
  - After release, lock must be re-acquired from zero.
- Latency: valid_o, data_o and locked_o are registered and assert the cycle after the sym_valid_i that carried the 3rd data symbol.
  - err_o asserts the cycle after the offending symbol.
- Strobe spacing of sym_valid_i: back-to-back symbols (every cycle) are supported; there is no backpressure.
- A saturating counter with a further qualifying event holds its saturated value.

## Structure
- Shared package ser_pkg holds:
  - COMMA = 8'h3C, KCODE = 1'b1, SYM_W = 9, FRAME_W = 27;
  - the deframer state enum.
- The transmit serializer is to be migrated to ser_pkg as well.
- No sub-module: one FSM plus two counters and a 27-bit capture register, all in this module.
- The serial bit receiver/decoder feeding sym_i is a separate block, connected at the top level.

## Test plan
- Lock acquisition: 4 frames of comma,{0,0x11},{0,0x22},{0,0x33}.
  - valid_o on the 4th only; locked_o rises with it; data_o = {9'h033, 9'h022, 9'h011}.
- Idle fill: locked, 10 commas then one frame.
  - No err_o; exactly one valid_o with the correct data.
  - Also check k=1 data {1,0xBC} in slot 1, which must appear at data_o[17:9].
- Abort: locked, comma,{0,0xAA},comma,{0,1},{0,2},{0,3}.
  - One err_o; the following frame is emitted as {9'h003, 9'h002, 9'h001}.
- Loss of lock: locked, two consecutive non-comma symbols in ST_IDLE.
  - Two err_o pulses; locked_o falls after the 2nd; the next 3 good frames are not emitted.
- Strobe gaps and reset: frames with sym_valid_i asserted every 10 cycles give identical results.
  - Assert rst_ni=0 between the 2nd and 3rd data symbols: all outputs go to 0 immediately, and 4 new frames are needed for lock.
